// File: rtl/bus_copy_master.sv
// Bus initiator that copies a block of DATA_W-bit words from a source to a destination range,
// one read-then-write transfer per word, re-issuing a word whenever the grant is lost.
module bus_copy_master #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LEN_W  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              m_req,
  input  logic              m_grant,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_dout,
  input  logic [DATA_W-1:0] m_din
);

  localparam logic [ADDR_W-1:0] Stride    = ADDR_W'(DATA_W / 8);
  localparam logic [ADDR_W-1:0] AlignMask = ~(Stride - ADDR_W'(1));

  typedef enum logic [2:0] {StIdle, StReq, StRd, StRwait, StWr, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   buf_q, buf_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  // Outputs decode only the registered state, so reset clears them asynchronously.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    busy    = 1'b0;
    done    = 1'b0;
    m_req   = 1'b0;
    m_wr    = 1'b0;
    m_addr  = '0;
    m_dout  = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d   = src_addr & AlignMask;
          dst_d   = dst_addr & AlignMask;
          cnt_d   = len;
          state_d = (len == '0) ? StDone : StReq;
        end
      end
      StReq: begin
        busy  = 1'b1;
        m_req = 1'b1;
        if (m_grant) state_d = StRd;
      end
      StRd: begin
        busy    = 1'b1;
        m_req   = 1'b1;
        m_addr  = src_q;
        state_d = m_grant ? StRwait : StReq;
      end
      StRwait: begin
        busy  = 1'b1;
        m_req = 1'b1;
        if (m_grant) begin
          buf_d   = m_din;
          state_d = StWr;
        end else begin
          state_d = StReq;
        end
      end
      StWr: begin
        busy   = 1'b1;
        m_req  = 1'b1;
        m_wr   = 1'b1;
        m_addr = dst_q;
        m_dout = buf_q;
        // A word is committed only if the grant survives its write cycle.
        if (m_grant) begin
          src_d   = src_q + Stride;
          dst_d   = dst_q + Stride;
          cnt_d   = cnt_q - LEN_W'(1);
          state_d = (cnt_q == LEN_W'(1)) ? StDone : StRd;
        end else begin
          state_d = StReq;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: doc/bus_copy_master.md
# bus_copy_master

Bus initiator that copies a block of 64-bit words from one address range to another over the shared single-master system bus. Software or a host FSM loads source, destination and length, then pulses `start`. The block then arbitrates for the bus with `m_req`/`m_grant` and performs read-then-write word transfers. It sits on the master port of the bus decoder, so it can move data between memory (slave 0) and the FactoCore register window (slave 1) in either direction.

## Interface
Parameters:
- `ADDR_W`, 16, bus byte-address width
- `DATA_W`, 64, bus data width; word stride = DATA_W/8 = 8 bytes
- `LEN_W`, 9, width of word-count input (0..511 words)

Ports:
- `clk`  in  1  single clock; everything is rising-edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle launch strobe; sampled only in IDLE
- `src_addr`  in  ADDR_W  byte address of first source word; bits [2:0] ignored (treated as 0)
- `dst_addr`  in  ADDR_W  byte address of first destination word; bits [2:0] ignored
- `len`  in  LEN_W  number of words to copy
- `busy`  out  1  high from the cycle after an accepted `start` until `done`
- `done`  out  1  one-cycle completion pulse
- `m_req`  out  1  bus request, held for the entire transfer
- `m_grant`  in  1  bus grant from the arbiter
- `m_wr`  out  1  1 = write cycle, 0 = read cycle
- `m_addr`  out  ADDR_W  bus byte address
- `m_dout`  out  DATA_W  write data to the bus
- `m_din`  in  DATA_W  read data from the bus; valid the cycle after the read-address cycle

## Operation
- Reset values: all outputs 0. FSM returns to IDLE. Counters, address registers and the data buffer are cleared. Reset mid-transfer abandons the copy: no `done`, and `m_req` drops asynchronously.
- States: IDLE, REQ, RD, RWAIT, WR, DONE.
- IDLE:
  - `start`=1 latches `src_addr`/`dst_addr` with bits [2:0] forced to 0, and latches `len` into the remaining-count register.
  - If `len`=0, go to DONE; the bus is never requested.
  - Otherwise go to REQ.
  - `start` in any other state is ignored.
- REQ: `m_req`=1, `m_wr`=0, `m_addr`=0. Stay in REQ until `m_grant`=1, then go to RD.
- RD: `m_req`=1, `m_wr`=0, `m_addr`=current source address. Go to RWAIT.
- RWAIT:
  - `m_req`=1, `m_wr`=0, `m_addr`=0.
  - Capture `m_din` into the 64-bit buffer at the end of the cycle.
  - Go to WR.
- WR:
  - `m_req`=1, `m_wr`=1, `m_addr`=current destination address, `m_dout`=buffer.
  - At the end of the cycle, add 8 to both addresses (modulo 2^ADDR_W; wrap from 0xFFF8 to 0x0000 is legal) and decrement the count.
  - If the count becomes 0, go to DONE; otherwise go to RD.
- DONE: `done`=1, `busy`=0, `m_req`=0. Go to IDLE next cycle.
- `m_dout` is 0 in every state except WR. `m_wr` is 1 only in WR.
- Grant loss:
  - If `m_grant`=0 in RD, RWAIT or WR, the current word is not committed: no address increment, no count decrement.
  - The FSM returns to REQ and, once re-granted, re-issues the same word starting from RD.
  - Words already written stay written.
- Overlapping ranges are not detected; the copy runs strictly ascending.

## Timing
- Accepted `start` at cycle 0 puts the FSM in REQ at cycle 1, with `busy`=1 and `m_req`=1.
- With `m_grant` held at 1, word k (0-based):
  - RD at cycle 2+3k
  - RWAIT at cycle 3+3k
  - WR at cycle 4+3k
- For len=N≥1 under continuous grant, `done` is at cycle 3N+2, and `m_req` is 0 in that cycle.
- For len=0, `done` is at cycle 1 and `busy` never asserts.
- Each extra cycle spent waiting in REQ delays every later event by exactly one cycle.
- Throughput is 3 cycles per word; there is no read/write overlap.

## Test plan
- Reset: hold `reset`=1 with random inputs, then release → all outputs 0 and FSM in IDLE; a `start` issued one cycle after release is accepted.
- Basic copy: RAM words 0x0000..0x0018 preloaded with 0x1111..1, 0x2222..2, 0x3333..3, 0x4444..4; `src_addr`=0x0000, `dst_addr`=0x0400, `len`=4, grant tied to `m_req` → reads at 0x0000/08/10/18 and writes at 0x0400/08/10/18 carry the same data, `done` at cycle 14, RAM 0x0400..0x0418 matches the source.
- Zero length: `len`=0 → `done` at cycle 1, `m_req` never asserts, `busy` stays 0.
- Grant delay and loss:
  - Grant is withheld 5 cycles → first RD at cycle 7.
  - With `len`=2, grant drops during the RWAIT of word 1 → FSM returns to REQ, word 1 is re-read from the same source address, exactly 2 writes occur, `done` asserts.
- Misaligned and wrap: `src_addr`=0xFFFD, `dst_addr`=0x0005, `len`=2 → reads at 0xFFF8 then 0x0000, writes at 0x0000 then 0x0008.
- Reset mid-transfer: assert `reset` during the WR of word 2 of 4 → `m_req`/`m_wr` drop immediately, no `done`, only words 0 and 1 are written; a new `start` then completes normally.
